// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, TX framer states,
// and default frame-length limits.
package eth_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  localparam int ETH_MIN_DATA = 60;
  localparam int ETH_MAX_DATA = 508;

  typedef enum logic [2:0] {
    DATA,
    PAD,
    FCS,
    WAIT_LAST,
    DISCARD
  } tx_fr_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 step over one byte.
// Ports: crc_in (running CRC), data (byte), crc_out (updated CRC).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: pads short frames, truncates long ones, appends FCS.
// Ports: ETH_CLK/ETH_RSTn, s_* input bytes, m_* output bytes to MAC,
// frame_done (last FCS byte taken), trunc_err (frame over MAX_DATA).
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_DATA = ETH_MIN_DATA,
  parameter int MAX_DATA = ETH_MAX_DATA
) (
  input  logic       ETH_CLK,
  input  logic       ETH_RSTn,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_done,
  output logic       trunc_err
);

  localparam int CW = $clog2(MAX_DATA + 1);

  tx_fr_state_t  state_q, state_d;
  logic [31:0]   crc_q, crc_d, crc_nx, fcs;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    idx_q, idx_d;
  logic          drop_q, drop_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          done_q, done_d;
  logic          trunc_q, trunc_d;
  logic          adv, in_xfer;
  logic [7:0]    crc_byte;
  int            cnt_nx;

  assign adv      = !m_valid_q || m_ready;
  assign s_ready  = ETH_RSTn &&
                    ((state_q == DATA && adv) || state_q == DISCARD);
  assign in_xfer  = s_valid && s_ready;
  assign crc_byte = (state_q == PAD) ? 8'h00 : s_data;
  assign fcs      = ~crc_q;
  assign cnt_nx   = int'(cnt_q) + 1;
  assign cnt_inc  = (int'(cnt_q) == MAX_DATA) ? cnt_q : cnt_q + CW'(1);

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = done_q;
  assign trunc_err  = trunc_q;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_nx)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    drop_d    = drop_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
    trunc_d   = 1'b0;
    unique case (state_q)
      DATA: begin
        if (in_xfer) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          crc_d     = crc_nx;
          cnt_d     = cnt_inc;
          if (s_last) begin
            state_d = (cnt_nx < MIN_DATA) ? PAD : FCS;
          end else if (cnt_nx == MAX_DATA) begin
            trunc_d = 1'b1;
            drop_d  = 1'b1;
            state_d = FCS;
          end
        end
      end
      PAD: begin
        if (adv) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'h00;
          m_last_d  = 1'b0;
          crc_d     = crc_nx;
          cnt_d     = cnt_inc;
          if (cnt_nx == MIN_DATA) state_d = FCS;
        end
      end
      FCS: begin
        if (adv) begin
          m_valid_d = 1'b1;
          m_data_d  = fcs[{idx_q, 3'b000} +: 8];
          m_last_d  = (idx_q == 2'd3);
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (m_valid_q && m_ready) begin
          done_d   = 1'b1;
          m_last_d = 1'b0;
          crc_d    = ETH_CRC_INIT;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = drop_q ? DISCARD : DATA;
        end
      end
      DISCARD: begin
        if (in_xfer && s_last) begin
          drop_d  = 1'b0;
          state_d = DATA;
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge ETH_CLK) begin
    if (!ETH_RSTn) begin
      state_q   <= DATA;
      crc_q     <= ETH_CRC_INIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      drop_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      drop_q    <= drop_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      trunc_q   <= trunc_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: default instance (MIN 60)
// and a MIN_DATA=9 instance, selected through a shared port mux.
module tb_eth_tx_framer;

  localparam int MAXD = 508;
  localparam int MINA = 60;
  localparam int MINB = 9;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sel = 1'b0;
  logic rdy_rand = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_last = 1'b0;
  logic m_ready = 1'b1;

  logic s_valid_a, s_ready_a, m_ready_a, m_valid_a, m_last_a;
  logic s_valid_b, s_ready_b, m_ready_b, m_valid_b, m_last_b;
  logic [7:0] m_data_a, m_data_b;
  logic done_a, done_b, trunc_a, trunc_b;
  logic s_ready, m_valid, m_last, frame_done, trunc_err;
  logic [7:0] m_data;

  int vecs = 0;
  int errs = 0;
  logic [8:0] exp_q[$];
  int lens_tbl[8] = '{1, 59, 60, 61, 507, 508, 509, 600};

  always #5 clk = ~clk;

  assign s_valid_a = s_valid & ~sel;
  assign s_valid_b = s_valid & sel;
  assign m_ready_a = sel | m_ready;
  assign m_ready_b = ~sel | m_ready;
  assign s_ready    = sel ? s_ready_b : s_ready_a;
  assign m_valid    = sel ? m_valid_b : m_valid_a;
  assign m_data     = sel ? m_data_b : m_data_a;
  assign m_last     = sel ? m_last_b : m_last_a;
  assign frame_done = sel ? done_b : done_a;
  assign trunc_err  = sel ? trunc_b : trunc_a;

  eth_tx_framer u_a (
    .ETH_CLK(clk), .ETH_RSTn(rstn),
    .s_valid(s_valid_a), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_last(m_last_a),
    .frame_done(done_a), .trunc_err(trunc_a)
  );

  eth_tx_framer #(.MIN_DATA(MINB), .MAX_DATA(MAXD)) u_b (
    .ETH_CLK(clk), .ETH_RSTn(rstn),
    .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_last(m_last_b),
    .frame_done(done_b), .trunc_err(trunc_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bitwise CRC-32 as defined: reflected, poly 0xEDB88320.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 8; j++) begin
      if ((r[0] ^ b[j]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  // Expected wire image of one frame for the currently selected instance.
  task automatic push_frame(input logic [7:0] f[$]);
    int mn;
    int n;
    logic [31:0] c;
    logic [7:0] b;
    mn = sel ? MINB : MINA;
    n = (f.size() > MAXD) ? MAXD : f.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n || i < mn; i++) begin
      b = (i < n) ? f[i] : 8'h00;
      c = crc_step(c, b);
      exp_q.push_back({1'b0, b});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, c[8*k +: 8]});
  endtask

  task automatic send(input logic [7:0] f[$], input bit gaps);
    int t;
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = (i == f.size() - 1);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) begin
        chk("s_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // m_ready driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor: observes both handshakes on the falling edge.
  logic        pend_done = 1'b0, pend_trunc = 1'b0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [31:0] run_crc = 32'hFFFFFFFF;
  int          in_cnt = 0;
  logic [8:0]  e;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      pend_done  = 1'b0;
      pend_trunc = 1'b0;
      prev_stall = 1'b0;
      in_cnt     = 0;
      run_crc    = 32'hFFFFFFFF;
    end else begin
      if (frame_done || pend_done)
        chk("frame_done", 32'(frame_done), 32'(pend_done));
      if (trunc_err || pend_trunc)
        chk("trunc_err", 32'(trunc_err), 32'(pend_trunc));
      pend_done  = 1'b0;
      pend_trunc = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data_last", {23'd0, m_last, m_data},
            {23'd0, prev_last, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", {23'd0, m_last, m_data}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", {23'd0, m_last, m_data}, {23'd0, e});
        end
        run_crc = crc_step(run_crc, m_data);
        if (m_last) begin
          pend_done = 1'b1;
          chk("residue", run_crc, RESIDUE);
          run_crc = 32'hFFFFFFFF;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (s_valid && s_ready) begin
        if (!s_last && in_cnt + 1 == MAXD) pend_trunc = 1'b1;
        in_cnt = s_last ? 0 : in_cnt + 1;
      end
    end
  end

  task automatic push_check_value();
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'h31 + 8'(i)});
    exp_q.push_back(9'h026);
    exp_q.push_back(9'h039);
    exp_q.push_back(9'h0F4);
    exp_q.push_back(9'h1CB);
  endtask

  initial begin
    logic [7:0] f[$];
    int len;
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    int len;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid_a | m_valid_b}, 32'd0);
    chk("rst_m_data", {24'd0, m_data_a | m_data_b}, 32'd0);
    chk("rst_m_last", {31'd0, m_last_a | m_last_b}, 32'd0);
    chk("rst_pulses", {30'd0, done_a | done_b, trunc_a | trunc_b}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready_a | s_ready_b}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", {31'd0, s_ready_a & s_ready_b}, 32'd1);
    @(posedge clk); #1;

    // CRC check value on the MIN_DATA=9 instance
    sel = 1'b1;
    f.delete();
    for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
    push_check_value();
    send(f, 1'b0);
    drain();

    // padding, truncation + follow-up, exact boundaries, backpressure
    sel = 1'b0;
    foreach (lens_tbl[k]) begin
      if (k == 0) len = 14;
      else if (k == 1) len = 600;
      else if (k == 2) len = 100;
      else if (k == 3) len = 60;
      else if (k == 4) len = 508;
      else len = 0;
      if (len != 0) begin
        f.delete();
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        push_frame(f);
        send(f, 1'b0);
        drain();
      end
    end
    rdy_rand = 1'b1;
    f.delete();
    for (int i = 0; i < 100; i++) f.push_back(8'($urandom));
    push_frame(f);
    send(f, 1'b0);
    drain();
    rdy_rand = 1'b0;

    // reset while the default instance is padding
    f.delete();
    for (int i = 0; i < 5; i++) f.push_back(8'($urandom));
    push_frame(f);
    send(f, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_m_valid", {31'd0, m_valid_a}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready_a}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_m_valid2", {31'd0, m_valid_a}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1;
    f.delete();
    for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
    push_check_value();
    send(f, 1'b0);
    drain();

    // randomized frames on both instances
    for (int r = 0; r < 16; r++) begin
      sel = 1'($urandom % 2);
      rdy_rand = 1'($urandom % 2);
      if ($urandom % 2 == 0) len = lens_tbl[$urandom % 8];
      else len = int'($urandom_range(1, 620));
      f.delete();
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      push_frame(f);
      send(f, 1'b1);
      drain();
    end
    rdy_rand = 1'b0;

    chk("leftover", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit framer that sits directly upstream of the loopback MAC's TX byte stream. It accepts raw frame bytes (destination address through payload) from the packet source. It zero-pads short frames to the minimum length, truncates over-long frames, and appends the 4-byte Ethernet FCS (CRC-32). The output is a valid/ready byte stream with a last marker that connects straight to the MAC's `tx_valid/tx_ready/tx_data/tx_last`.

## Interface

Parameters:
- `MIN_DATA`, default 60: minimum bytes before the FCS. Shorter frames are zero-padded up to this length.
- `MAX_DATA`, default 508: maximum bytes before the FCS. 508 + 4 = 512, which matches the MAC frame limit.

Ports:
- `ETH_CLK`, in, 1: the only clock.
- `ETH_RSTn`, in, 1: synchronous, active-low reset, sampled on the rising edge of `ETH_CLK`.
- `s_valid`, in, 1: input byte valid.
- `s_ready`, out, 1: framer can accept an input byte.
- `s_data`, in, 8: input byte.
- `s_last`, in, 1: last input byte of the frame.
- `m_valid`, out, 1: output byte valid (drives MAC `tx_valid`).
- `m_ready`, in, 1: from MAC `tx_ready`.
- `m_data`, out, 8: output byte.
- `m_last`, out, 1: final FCS byte.
- `frame_done`, out, 1: one-cycle pulse when the last FCS byte is accepted downstream.
- `trunc_err`, out, 1: one-cycle pulse when a frame exceeds `MAX_DATA`.

## Operation

- A byte transfers when valid && ready on a rising edge. This applies on both sides.
- Output register: `m_valid/m_data/m_last` are registered.
  - The register loads a new byte only when `!m_valid || m_ready` ("adv").
- `s_ready = (state==DATA) && adv`. This is combinational.
- `byte_cnt` counts bytes emitted before the FCS.
  - It is $clog2(MAX_DATA+1) bits wide and saturates at `MAX_DATA`.
- CRC-32 (reflected) settings:
  - Polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - The CRC is updated on every data byte and every pad byte as it loads into the output register.
  - FCS = ~crc, sent LSB byte first.
- State machine:
  - **DATA** (after reset). On an accepted byte: load it, update the CRC, increment `byte_cnt`.
    - `s_last` with `byte_cnt+1 < MIN_DATA` → PAD.
    - `s_last` otherwise → FCS.
    - No `s_last` and `byte_cnt+1 == MAX_DATA` → pulse `trunc_err`, go to FCS, and set `drop_rest`.
  - **PAD**: on each adv, load 0x00, update the CRC, increment `byte_cnt`. When `byte_cnt+1 == MIN_DATA` → FCS. `s_ready` = 0.
  - **FCS**: on each adv, load FCS byte `idx` (0..3). `m_last` = 1 on `idx` 3.
    - After loading `idx` 3 → WAIT_LAST.
  - **WAIT_LAST**: when `m_valid && m_ready` for the last byte, pulse `frame_done`, reset the CRC, `byte_cnt` and `idx`.
    - Then go to DISCARD if `drop_rest` is set, else to DATA. `s_ready` = 0 in this state.
  - **DISCARD**: `s_ready` = 1 and `m_valid` stays 0. Accepted bytes are dropped. The byte with `s_last` → DATA, and `drop_rest` clears.
- A truncated frame whose byte number `MAX_DATA` carries `s_last` is not an error. It goes to FCS normally with no `trunc_err`.

## Timing

- Reset values: `m_valid` 0, `m_data` 0x00, `m_last` 0, `frame_done` 0, `trunc_err` 0, state DATA, CRC 0xFFFFFFFF, `drop_rest` 0.
- `s_ready` is 0 while `ETH_RSTn` is low.
- Latency: an input byte appears on `m_data` one cycle after it is accepted.
- Throughput: one byte per cycle when `m_ready` is held high.
- The inter-frame gap is at least one cycle (the WAIT_LAST state).
- Backpressure: while `m_valid && !m_ready`, `m_data`, `m_last` and `m_valid` hold stable and the state does not advance.
- The framer never deasserts `m_valid` without a transfer occurring.
- Reset mid-frame: the partial output is abandoned with no `m_last`. The next frame starts clean. The downstream MAC is reset together with the framer.
- `frame_done` is asserted in the cycle after the last-byte handshake.
- `trunc_err` is asserted in the cycle after the `MAX_DATA`-th byte is accepted.

## Structure

- Shared package `eth_pkg` contains:
  - CRC constants `ETH_CRC_POLY = 32'hEDB88320`, `ETH_CRC_INIT = 32'hFFFFFFFF`, `ETH_CRC_RESIDUE = 32'hDEBB20E3`.
  - Framer state enum `tx_fr_state_t` (DATA, PAD, FCS, WAIT_LAST, DISCARD).
  - Defaults for `MIN_DATA` and `MAX_DATA`.
- Sub-module `eth_crc32_byte`: purely combinational next-CRC computed from (crc_in, byte). It is reused by a future RX FCS checker.

## Test plan

- Test 1, CRC check value:
  - Stimulus: `MIN_DATA`=9, input ASCII "123456789" back-to-back, `m_ready`=1.
  - Response: output is 31..39, then 0x26 0x39 0xF4 0xCB with `m_last` on 0xCB, then `frame_done` pulses once.
- Test 2, padding:
  - Stimulus: defaults, 14-byte frame.
  - Response: 14 data bytes, 46 bytes of 0x00, 4 FCS bytes (64 total), `m_last` only on byte 64.
  - The CRC over all 64 output bytes equals the residue 0xDEBB20E3.
- Test 3, truncation:
  - Stimulus: 600-byte input frame.
  - Response: 508 data bytes plus 4 FCS bytes, `trunc_err` pulses once, the remaining 92 bytes are accepted and dropped.
  - The next frame is emitted intact.
- Test 4, exact boundaries:
  - Stimulus: 60-byte frame, then a 508-byte frame.
  - Response: 64 and 512 output bytes, no pad bytes, no `trunc_err`.
- Test 5, backpressure:
  - Stimulus: random `m_ready` (50%) on a 100-byte frame.
  - Response: `m_data` and `m_last` are stable while stalled, the byte order and FCS are identical to the `m_ready`=1 run, and no bytes are lost or duplicated.
- Test 6, reset mid-frame:
  - Stimulus: assert `ETH_RSTn`=0 for 2 cycles during PAD, then send "123456789" with `MIN_DATA`=9.
  - Response: `m_valid` is 0 during reset and the output after reset matches Test 1 exactly.
